frame_bit_injector: RTL and testbench

//  Parametrised multi-bit fault injector in the partial-reconfiguration frame write path.

---
 rtl/frame_bit_injector_pkg.sv | 30 +++
 rtl/frame_bit_injector_bit_loc_decode.sv | 26 ++
 rtl/frame_bit_injector.sv | 215 +++++++++++++++++++++
 tb/tb_frame_bit_injector.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_bit_injector_pkg.sv
// Shared types, default widths and the location decode helper for frame_bit_injector.
package fi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fi_state_e;

  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 13;
  localparam int LOC_W_DEF       = 12;
  localparam int FRAME_BASE_DEF  = 105;
  localparam int FRAME_WORDS_DEF = 101;
  localparam int BIT_W_DEF       = $clog2(DATA_W_DEF);

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] target;
    logic [DATA_W_DEF-1:0] mask;
  } loc_dec_t;

  // Decode for the default geometry; parametrised builds use bit_loc_decode.
  function automatic loc_dec_t loc_target(input logic [LOC_W_DEF-1:0] loc);
    loc_dec_t r;
    r.target = ADDR_W_DEF'(FRAME_BASE_DEF) + ADDR_W_DEF'(loc >> BIT_W_DEF);
    r.mask   = DATA_W_DEF'(1) << loc[BIT_W_DEF-1:0];
    return r;
  endfunction

endpackage

// File: rtl/frame_bit_injector_bit_loc_decode.sv
// Combinational decode of a zero-based frame bit location into stream address, bit mask and range flag.
module bit_loc_decode
  import fi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LOC_W       = LOC_W_DEF,
  parameter int FRAME_BASE  = FRAME_BASE_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic [LOC_W-1:0]  loc,
  output logic [ADDR_W-1:0] target,
  output logic [DATA_W-1:0] mask,
  output logic              in_range
);

  localparam int          BIT_W = $clog2(DATA_W);
  localparam logic [31:0] LIMIT = 32'(FRAME_WORDS * DATA_W);

  always_comb begin
    target   = ADDR_W'(FRAME_BASE) + ADDR_W'(loc >> BIT_W);
    mask     = DATA_W'(1) << loc[BIT_W-1:0];
    in_range = 32'(loc) < LIMIT;
  end

endmodule

// File: rtl/frame_bit_injector.sv
// Multi-bit fault injector on the frame write stream: XORs armed bit locations into matching words.
// Optional INJ_DEBUG_EN adds dbg_addr/dbg_orig/dbg_mod capturing the last modified word.
//
// state | meaning
// IDLE  | table loadable, stream passes unmodified
// RUN   | stream words matched against armed entries and masked
// DONE  | one cycle: table emptied, done pulse issued next cycle
module frame_bit_injector
  import fi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LOC_W       = LOC_W_DEF,
  parameter int FRAME_BASE  = FRAME_BASE_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int MAX_FLIPS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           loc_valid,
  output logic                           loc_ready,
  input  logic [LOC_W-1:0]               loc_data,
  input  logic                           start,
  output logic                           busy,
  input  logic                           in_valid,
  input  logic [ADDR_W-1:0]              in_addr,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           out_valid,
  output logic [ADDR_W-1:0]              out_addr,
  output logic [DATA_W-1:0]              out_data,
  output logic                           done,
  output logic [$clog2(MAX_FLIPS+1)-1:0] flip_count,
  output logic                           err_range
`ifdef INJ_DEBUG_EN
  ,
  output logic [ADDR_W-1:0]              dbg_addr,
  output logic [DATA_W-1:0]              dbg_orig,
  output logic [DATA_W-1:0]              dbg_mod
`endif
);

  localparam int               CNT_W     = $clog2(MAX_FLIPS + 1);
  localparam logic [1:0]       ST_IDLE   = IDLE;
  localparam logic [1:0]       ST_RUN    = RUN;
  localparam logic [1:0]       ST_DONE   = DONE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BASE + FRAME_WORDS - 1);

  logic [1:0]           state_q, state_d;
  logic [MAX_FLIPS-1:0] valid_q, valid_d;
  logic [MAX_FLIPS-1:0] hit_q, hit_d;
  logic [ADDR_W-1:0]    target_q [MAX_FLIPS];
  logic [ADDR_W-1:0]    target_d [MAX_FLIPS];
  logic [DATA_W-1:0]    mask_q   [MAX_FLIPS];
  logic [DATA_W-1:0]    mask_d   [MAX_FLIPS];
  logic [CNT_W-1:0]     flip_count_q, flip_count_d;
  logic                 done_q, done_d;
  logic                 err_range_q, err_range_d;
  logic                 out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;

  logic [ADDR_W-1:0]    dec_target;
  logic [DATA_W-1:0]    dec_mask;
  logic                 dec_in_range;
  logic                 loc_fire;
  logic                 slot_found;
  logic [DATA_W-1:0]    word_mask;

  bit_loc_decode #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .LOC_W       (LOC_W),
    .FRAME_BASE  (FRAME_BASE),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_decode (
    .loc      (loc_data),
    .target   (dec_target),
    .mask     (dec_mask),
    .in_range (dec_in_range)
  );

  // Entries fill from slot 0 upward, so the table is full exactly when every slot is valid.
  assign loc_ready = (state_q == ST_IDLE) && !(&valid_q);
  assign loc_fire  = loc_valid && loc_ready;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    hit_d        = hit_q;
    target_d     = target_q;
    mask_d       = mask_q;
    flip_count_d = flip_count_q;
    done_d       = (state_q == ST_DONE);
    err_range_d  = loc_fire && !dec_in_range;
    slot_found   = 1'b0;
    word_mask    = '0;

    if (loc_fire && dec_in_range) begin
      for (int i = 0; i < MAX_FLIPS; i++) begin
        if (!valid_q[i] && !slot_found) begin
          valid_d[i]  = 1'b1;
          target_d[i] = dec_target;
          mask_d[i]   = dec_mask;
          slot_found  = 1'b1;
        end
      end
    end

    // Each armed entry is applied at most once per run.
    if (state_q == ST_RUN && in_valid) begin
      for (int i = 0; i < MAX_FLIPS; i++) begin
        if (valid_q[i] && !hit_q[i] && target_q[i] == in_addr) begin
          word_mask    = word_mask | mask_q[i];
          hit_d[i]     = 1'b1;
          flip_count_d = flip_count_d + CNT_W'(1);
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hit_d        = '0;
          flip_count_d = '0;
          state_d      = (valid_d == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (hit_d == valid_q || (in_valid && in_addr == LAST_ADDR)) state_d = ST_DONE;
      end
      ST_DONE: begin
        valid_d = '0;
        hit_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = in_valid;
    out_addr_d  = in_addr;
    out_data_d  = in_data ^ word_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      hit_q        <= '0;
      flip_count_q <= '0;
      done_q       <= 1'b0;
      err_range_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      for (int i = 0; i < MAX_FLIPS; i++) begin
        target_q[i] <= '0;
        mask_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      hit_q        <= hit_d;
      flip_count_q <= flip_count_d;
      done_q       <= done_d;
      err_range_q  <= err_range_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      target_q     <= target_d;
      mask_q       <= mask_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign done       = done_q;
  assign flip_count = flip_count_q;
  assign err_range  = err_range_q;

`ifdef INJ_DEBUG_EN
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0] dbg_orig_q, dbg_orig_d;
  logic [DATA_W-1:0] dbg_mod_q, dbg_mod_d;

  always_comb begin
    dbg_addr_d = dbg_addr_q;
    dbg_orig_d = dbg_orig_q;
    dbg_mod_d  = dbg_mod_q;
    if (word_mask != '0) begin
      dbg_addr_d = in_addr;
      dbg_orig_d = in_data;
      dbg_mod_d  = in_data ^ word_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_addr_q <= '0;
      dbg_orig_q <= '0;
      dbg_mod_q  <= '0;
    end else begin
      dbg_addr_q <= dbg_addr_d;
      dbg_orig_q <= dbg_orig_d;
      dbg_mod_q  <= dbg_mod_d;
    end
  end

  assign dbg_addr = dbg_addr_q;
  assign dbg_orig = dbg_orig_q;
  assign dbg_mod  = dbg_mod_q;
`endif

endmodule

// File: tb/tb_frame_bit_injector.sv
// Scoreboard bench for frame_bit_injector: directed scenarios plus randomized runs against a list-based model.
module tb_frame_bit_injector;

  localparam int BASE  = 105;
  localparam int WORDS = 101;
  localparam int LAST  = BASE + WORDS - 1;
  localparam int NLOC  = WORDS * 32;
  localparam int MAXF  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        loc_valid;
  logic        loc_ready;
  logic [11:0] loc_data;
  logic        start;
  logic        busy;
  logic        in_valid;
  logic [12:0] in_addr;
  logic [31:0] in_data;
  logic        out_valid;
  logic [12:0] out_addr;
  logic [31:0] out_data;
  logic        done;
  logic [2:0]  flip_count;
  logic        err_range;

  frame_bit_injector dut (
    .clk        (clk),
    .rst        (rst),
    .loc_valid  (loc_valid),
    .loc_ready  (loc_ready),
    .loc_data   (loc_data),
    .start      (start),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .done       (done),
    .flip_count (flip_count),
    .err_range  (err_range)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned addr;
    int unsigned data;
    bit          last;
  } exp_t;

  exp_t        expq[$];
  int          exp_done[$];
  int          checks   = 0;
  int          failures = 0;

  // Reference model: armed locations, their hit flags, and run status.
  int unsigned locs[$];
  bit          hitm[$];
  bit          running_m = 1'b0;
  int          flips_m   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   exp_now;
    if (out_valid) begin
      if (expq.size() == 0) begin
        check("unexpected_out", {51'd0, out_addr}, 64'hFFFF);
      end else begin
        e = expq.pop_front();
        check("out_addr", {51'd0, out_addr}, 64'(e.addr));
        check("out_data", {32'd0, out_data}, 64'(e.data));
        if (e.last) exp_done.push_back(cyc + 1);
      end
    end
    while (exp_done.size() > 0 && exp_done[0] < cyc) begin
      void'(exp_done.pop_front());
      check("missed_done", 64'd0, 64'd1);
    end
    exp_now = (exp_done.size() > 0) && (exp_done[0] == cyc);
    if (done || exp_now) begin
      check("done", {63'd0, done}, {63'd0, exp_now});
      if (exp_now) void'(exp_done.pop_front());
    end
  end

  task automatic end_run_model();
    running_m = 1'b0;
    locs.delete();
    hitm.delete();
  endtask

  task automatic ctl(input bit lv, input int unsigned loc, input bit st);
    bit exp_ready;
    bit acc;
    bit in_rng;
    exp_ready = (locs.size() < MAXF);
    loc_valid = lv;
    loc_data  = loc[11:0];
    start     = st;
    if (lv) check("loc_ready", {63'd0, loc_ready}, {63'd0, exp_ready});
    acc    = lv && exp_ready;
    in_rng = loc < NLOC;
    if (acc && in_rng) begin
      locs.push_back(loc);
      hitm.push_back(1'b0);
    end
    if (st) begin
      flips_m = 0;
      foreach (hitm[i]) hitm[i] = 1'b0;
      if (locs.size() == 0) begin
        exp_done.push_back(cyc + 2);
        end_run_model();
      end else begin
        running_m = 1'b1;
      end
    end
    tick();
    loc_valid = 1'b0;
    start     = 1'b0;
    if (lv) check("err_range", {63'd0, err_range}, {63'd0, acc && !in_rng});
    if (st) check("busy", {63'd0, busy}, {63'd0, running_m});
  endtask

  task automatic word(input int unsigned addr, input int unsigned data, input bit st);
    int unsigned mask = 0;
    bit          last = 1'b0;
    bit          all  = 1'b1;
    in_valid = 1'b1;
    in_addr  = addr[12:0];
    in_data  = data;
    start    = st && running_m;
    if (running_m) begin
      foreach (locs[i]) begin
        if (!hitm[i] && BASE + locs[i] / 32 == addr) begin
          mask    = mask | (32'd1 << (locs[i] % 32));
          hitm[i] = 1'b1;
          flips_m++;
        end
        if (!hitm[i]) all = 1'b0;
      end
      if (all || addr == LAST) begin
        last = 1'b1;
        end_run_model();
      end
    end
    expq.push_back('{addr: addr, data: data ^ mask, last: last});
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
    in_addr  = 13'($urandom);
    in_data  = $urandom;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_addr  = 13'($urandom_range(BASE, LAST));
    in_data  = $urandom;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_done.size() > 0 || expq.size() > 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", 64'd1, 64'd0);
    tick();
    check("flip_count", {61'd0, flip_count}, 64'(flips_m));
    check("idle_loc_ready", {63'd0, loc_ready}, 64'd1);
    check("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic full_frame(input int unsigned data, input int skip_addr);
    for (int a = BASE; a <= LAST; a++) begin
      if (a != skip_addr) word(a, data, 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    loc_valid = 1'b0;
    loc_data  = '0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    repeat (3) tick();
    check("rst_loc_ready", {63'd0, loc_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_flip_count", {61'd0, flip_count}, 64'd0);
    check("rst_err_range", {63'd0, err_range}, 64'd0);
    rst = 1'b0;
    tick();

    // Single flip in word 107 bit 6.
    ctl(1'b1, 70, 1'b0);
    ctl(1'b0, 0, 1'b1);
    full_frame(32'hFFFF0000, -1);
    wait_idle();
    check("t1_flip_count", {61'd0, flip_count}, 64'd1);

    // Two flips in the same word.
    ctl(1'b1, 0, 1'b0);
    ctl(1'b1, 31, 1'b0);
    ctl(1'b0, 0, 1'b1);
    word(BASE, 32'h0, 1'b0);
    wait_idle();
    check("t2_flip_count", {61'd0, flip_count}, 64'd2);

    // Out-of-range location, then an empty run.
    ctl(1'b1, NLOC, 1'b0);
    ctl(1'b0, 0, 1'b1);
    wait_idle();

    // Full table refuses a fifth location; edge of range included.
    ctl(1'b1, 5, 1'b0);
    ctl(1'b1, 40, 1'b0);
    ctl(1'b1, 1000, 1'b0);
    ctl(1'b1, NLOC - 1, 1'b0);
    ctl(1'b1, 77, 1'b0);
    ctl(1'b0, 0, 1'b1);
    full_frame($urandom, -1);
    wait_idle();
    check("t4_flip_count", {61'd0, flip_count}, 64'd4);

    // Reset in the middle of a run.
    ctl(1'b1, 70, 1'b0);
    ctl(1'b0, 0, 1'b1);
    word(BASE, 32'h1234_5678, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_addr  = 13'(BASE + 1);
    in_data  = 32'hDEAD_BEEF;
    tick();
    end_run_model();
    flips_m = 0;
    check("t5_out_valid", {63'd0, out_valid}, 64'd0);
    check("t5_loc_ready", {63'd0, loc_ready}, 64'd1);
    check("t5_busy", {63'd0, busy}, 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (4) tick();
    ctl(1'b0, 0, 1'b1);
    wait_idle();

    // Missing target word: the last frame word ends the run.
    ctl(1'b1, 100, 1'b0);
    ctl(1'b0, 0, 1'b1);
    full_frame(32'hA5A5_5A5A, BASE + 3);
    wait_idle();
    check("t6_flip_count", {61'd0, flip_count}, 64'd0);

    // Randomized runs: duplicates, out-of-range, start with a load, stray starts, gaps, skipped words.
    for (int r = 0; r < 10; r++) begin
      int          n;
      int unsigned loc;
      bit          combo;
      n     = $urandom_range(0, 5);
      combo = $urandom_range(0, 1);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 5))
          0:       loc = $urandom_range(NLOC, 4095);
          1:       loc = (locs.size() > 0) ? locs[locs.size() - 1] : $urandom_range(0, NLOC - 1);
          default: loc = $urandom_range(0, NLOC - 1);
        endcase
        ctl(1'b1, loc, combo && (k == n - 1));
      end
      if (!(combo && n > 0)) ctl(1'b0, 0, 1'b1);
      for (int a = BASE - 2; a <= LAST; a++) begin
        if ($urandom_range(0, 3) == 0) gap();
        if (a == LAST || $urandom_range(0, 9) != 0) word(a, $urandom, $urandom_range(0, 19) == 0);
      end
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
